mc_control_fsm: RTL

- Multicycle successor to the single-cycle combinational decoder.
- Accepts one 32-bit instruction via a valid/ready handshake and latches it into an internal IR.
- Sequences the datapath through decode, execute, memory and writeback states, driving per-state control strobes.
- Supports a configurable multi-cycle MUL, a variable-latency memory handshake, and illegal-instruction reporting.

---
 rtl/mc_control_fsm.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/mc_control_fsm.sv
// Multicycle control FSM: accepts one instruction into IR, then sequences
// decode/execute/memory/writeback with per-state control strobes.
module mc_control_fsm #(
   parameter int unsigned INSTR_W    = 32,
   parameter int unsigned MUL_CYCLES = 4,
   parameter logic [5:0]  OPC_R      = 6'b000100,
   parameter logic [5:0]  OPC_LW     = 6'b000101,
   parameter logic [5:0]  OPC_SW     = 6'b000110
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INSTR_W-1:0] instr,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic               mem_ready,
   output logic               ir_write,
   output logic               alu_src,
   output logic [2:0]         alu_op,
   output logic               mul_start,
   output logic               mem_read,
   output logic               mem_write,
   output logic               reg_write,
   output logic               reg_dst,
   output logic               mem_to_reg,
   output logic [4:0]         dest_reg,
   output logic               pc_write,
   output logic               done,
   output logic               illegal,
   output logic               busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_DECODE, S_EXEC, S_MUL_WAIT, S_MEM_RD, S_MEM_WR, S_WB
   } state_t;

   typedef enum logic [2:0] {
      K_ADD, K_SUB, K_AND, K_OR, K_MUL, K_LW, K_SW, K_BAD
   } kind_t;

   state_t               r_state;
   state_t               w_next;
   logic [INSTR_W-1:0]   r_ir;
   logic [7:0]           r_mul_cnt;
   kind_t                w_kind;
   logic [5:0]           w_opc;
   logic [5:0]           w_funct;
   logic                 w_unused_ir;

   assign w_opc       = r_ir[INSTR_W-1 -: 6];
   assign w_funct     = r_ir[5:0];
   assign w_unused_ir = ^r_ir;

   always_comb begin
      w_kind = K_BAD;
      if (w_opc == OPC_R) begin
         case (w_funct)
            6'b100000: w_kind = K_ADD;
            6'b100010: w_kind = K_SUB;
            6'b110010: w_kind = K_MUL;
            6'b100100: w_kind = K_AND;
            6'b100101: w_kind = K_OR;
            default:   w_kind = K_BAD;
         endcase
      end else if (w_opc == OPC_LW) begin
         w_kind = K_LW;
      end else if (w_opc == OPC_SW) begin
         w_kind = K_SW;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_ir      <= '0;
         r_mul_cnt <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && instr_valid) begin
            r_ir <= instr;
         end
         // Counter is preloaded with MUL_CYCLES-1 so MUL_WAIT lasts exactly MUL_CYCLES cycles
         if (r_state == S_EXEC && w_kind == K_MUL) begin
            r_mul_cnt <= 8'(MUL_CYCLES - 1);
         end else if (r_state == S_MUL_WAIT && r_mul_cnt != '0) begin
            r_mul_cnt <= r_mul_cnt - 8'd1;
         end
      end
   end

   always_comb begin
      w_next      = r_state;
      instr_ready = 1'b0;
      ir_write    = 1'b0;
      alu_src     = 1'b0;
      alu_op      = 3'b000;
      mul_start   = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      reg_write   = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      pc_write    = 1'b0;
      done        = 1'b0;
      illegal     = 1'b0;
      busy        = (r_state != S_IDLE);

      case (r_state)
         S_IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               ir_write = 1'b1;
               w_next   = S_DECODE;
            end
         end
         S_DECODE: begin
            if (w_kind == K_BAD) begin
               illegal  = 1'b1;
               done     = 1'b1;
               pc_write = 1'b1;
               w_next   = S_IDLE;
            end else begin
               w_next = S_EXEC;
            end
         end
         S_EXEC: begin
            alu_src = (w_kind == K_LW) || (w_kind == K_SW);
            case (w_kind)
               K_ADD: begin alu_op = 3'b000; w_next = S_WB; end
               K_SUB: begin alu_op = 3'b001; w_next = S_WB; end
               K_AND: begin alu_op = 3'b010; w_next = S_WB; end
               K_OR:  begin alu_op = 3'b011; w_next = S_WB; end
               K_MUL: begin
                  alu_op    = 3'b100;
                  mul_start = 1'b1;
                  w_next    = S_MUL_WAIT;
               end
               K_LW:    w_next = S_MEM_RD;
               K_SW:    w_next = S_MEM_WR;
               default: w_next = S_IDLE;
            endcase
         end
         S_MUL_WAIT: begin
            alu_op = 3'b100;
            if (r_mul_cnt == '0) begin
               w_next = S_WB;
            end
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            if (mem_ready) begin
               w_next = S_WB;
            end
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            if (mem_ready) begin
               pc_write = 1'b1;
               done     = 1'b1;
               w_next   = S_IDLE;
            end
         end
         S_WB: begin
            reg_write  = 1'b1;
            pc_write   = 1'b1;
            done       = 1'b1;
            reg_dst    = (w_opc == OPC_R);
            mem_to_reg = (w_kind == K_LW);
            w_next     = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase

      dest_reg = reg_dst ? r_ir[15:11] : r_ir[20:16];

      // Reset masks every output combinationally, before the state register clears
      if (rst) begin
         instr_ready = 1'b0;
         ir_write    = 1'b0;
         alu_src     = 1'b0;
         alu_op      = 3'b000;
         mul_start   = 1'b0;
         mem_read    = 1'b0;
         mem_write   = 1'b0;
         reg_write   = 1'b0;
         reg_dst     = 1'b0;
         mem_to_reg  = 1'b0;
         dest_reg    = 5'd0;
         pc_write    = 1'b0;
         done        = 1'b0;
         illegal     = 1'b0;
         busy        = 1'b0;
      end
   end

endmodule
